// File: rtl/e_pkg.sv
// ============================================================================
// e_pkg : shared types and helpers for the e_ arbitration blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package e_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } e_arb_state_t;

    // Pointer increment that wraps at n; an explicit compare, so non-power-of-2 n works
    function automatic logic [31:0] ptr_inc(input logic [31:0] idx, input logic [31:0] n);
        return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/e_pri_chain.sv
// ============================================================================
// e_pri_chain : first-set search from a one-hot start position, with wrap
// Rev 1.0
// ============================================================================
`default_nettype none

module e_pri_chain #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] start_i,
    output logic [N-1:0] win_o,
    output logic         vld_o
);

    logic [N-1:0] w_mask_hi;
    logic [N-1:0] w_req_hi;

    // Bits at or above the start position; when none of those request, wrap to bit 0
    assign w_mask_hi = ~(start_i - {{(N-1){1'b0}}, 1'b1});
    assign w_req_hi  = req_i & w_mask_hi;

    always_comb begin
        win_o = '0;
        if (|w_req_hi) begin
            win_o = w_req_hi & (~w_req_hi + {{(N-1){1'b0}}, 1'b1});
        end else begin
            win_o = req_i & (~req_i + {{(N-1){1'b0}}, 1'b1});
        end
    end

    assign vld_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/e_rr_arb.sv
// ============================================================================
// e_rr_arb : N-way round-robin / fixed-priority arbiter, registered grants
// Rev 1.0
// ============================================================================
`default_nettype none

module e_rr_arb
    import e_pkg::*;
#(
    parameter int N  = 8,
    parameter int RR = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic                 ack_i,
    output logic [N-1:0]         gnt_o,
    output logic                 gnt_vld_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);

    localparam int IDX_W = $clog2(N);

    e_arb_state_t     state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

    logic [31:0]      w_ptr_inc32;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_search_ptr;
    logic [N-1:0]     w_start_oh;
    logic [N-1:0]     w_win;
    logic             w_win_vld;
    logic [IDX_W-1:0] w_win_idx;

    assign w_ptr_inc32 = ptr_inc(32'(gnt_idx_q), 32'(N));

    generate
        if (RR != 0) begin : g_rr
            assign w_ptr_nxt = w_ptr_inc32[IDX_W-1:0];
        end else begin : g_fixed
            assign w_ptr_nxt = '0;
        end
    endgenerate

    // On an ack the search already uses the advanced pointer, so there is no bubble
    assign w_search_ptr = (state_q == BUSY) ? w_ptr_nxt : ptr_q;
    assign w_start_oh   = {{(N-1){1'b0}}, 1'b1} << w_search_ptr;

    e_pri_chain #(
        .N (N)
    ) u_pri_chain (
        .req_i   (req_i),
        .start_i (w_start_oh),
        .win_o   (w_win),
        .vld_o   (w_win_vld)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win[i]) begin
                w_win_idx = w_win_idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        case (state_q)
            IDLE: begin
                if (w_win_vld) begin
                    gnt_d     = w_win;
                    gnt_idx_d = w_win_idx;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (ack_i) begin
                    ptr_d = w_ptr_nxt;
                    if (w_win_vld) begin
                        gnt_d     = w_win;
                        gnt_idx_d = w_win_idx;
                    end else begin
                        gnt_d     = '0;
                        gnt_idx_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_vld_o = |gnt_q;
    assign gnt_idx_o = gnt_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_e_rr_arb.sv
// ============================================================================
// tb_e_rr_arb : directed self-checking bench for e_rr_arb (N=4 RR, N=5 RR, N=4 fixed)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_e_rr_arb;

    logic       clk;
    logic       rst_n;

    logic [3:0] req_a, gnt_a;
    logic       ack_a, vld_a;
    logic [1:0] idx_a;

    logic [4:0] req_b, gnt_b;
    logic       ack_b, vld_b;
    logic [2:0] idx_b;

    logic [3:0] req_c, gnt_c;
    logic       ack_c, vld_c;
    logic [1:0] idx_c;

    int n_cmp;
    int n_err;

    e_rr_arb #(.N(4), .RR(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_i(req_a), .ack_i(ack_a),
        .gnt_o(gnt_a), .gnt_vld_o(vld_a), .gnt_idx_o(idx_a)
    );

    e_rr_arb #(.N(5), .RR(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_i(req_b), .ack_i(ack_b),
        .gnt_o(gnt_b), .gnt_vld_o(vld_b), .gnt_idx_o(idx_b)
    );

    e_rr_arb #(.N(4), .RR(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .req_i(req_c), .ack_i(ack_c),
        .gnt_o(gnt_c), .gnt_vld_o(vld_c), .gnt_idx_o(idx_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] i);
        chk({tag, "_gnt"}, 32'(gnt_a), 32'(g));
        chk({tag, "_idx"}, 32'(idx_a), 32'(i));
        chk({tag, "_vld"}, 32'(vld_a), 32'(|g));
    endtask

    task automatic chk_b(input string tag, input logic [4:0] g, input logic [2:0] i);
        chk({tag, "_gnt"}, 32'(gnt_b), 32'(g));
        chk({tag, "_idx"}, 32'(idx_b), 32'(i));
        chk({tag, "_vld"}, 32'(vld_b), 32'(|g));
    endtask

    task automatic chk_c(input string tag, input logic [3:0] g, input logic [1:0] i);
        chk({tag, "_gnt"}, 32'(gnt_c), 32'(g));
        chk({tag, "_idx"}, 32'(idx_c), 32'(i));
        chk({tag, "_vld"}, 32'(vld_c), 32'(|g));
    endtask

    // Grants must be one-hot or zero in every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot_a", 32'($onehot0(gnt_a)), 32'd1);
            chk("onehot_b", 32'($onehot0(gnt_b)), 32'd1);
            chk("onehot_c", 32'($onehot0(gnt_c)), 32'd1);
        end
    end

    // Expected rotation sequence for all-requesting with ack held, starting after grant 3
    logic [1:0] rot_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req_a = '0; ack_a = 1'b0;
        req_b = '0; ack_b = 1'b0;
        req_c = '0; ack_c = 1'b0;
        tick();
        tick();
        chk_a("rst_a", 4'b0000, 2'd0);
        chk_b("rst_b", 5'b00000, 3'd0);
        chk_c("rst_c", 4'b0000, 2'd0);
        rst_n = 1'b1;

        // Idle with stray acks
        for (int k = 0; k < 5; k++) begin
            ack_a = k[0];
            ack_c = k[0];
            tick();
            chk_a("idle_a", 4'b0000, 2'd0);
            chk_c("idle_c", 4'b0000, 2'd0);
        end
        ack_a = 1'b0;
        ack_c = 1'b0;

        // Single request, one-cycle latency, hold without ack
        req_a = 4'b0100;
        tick();
        chk_a("single", 4'b0100, 2'd2);
        req_a = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_a("hold", 4'b0100, 2'd2);
        end
        ack_a = 1'b1;
        req_a = 4'b0000;
        tick();
        chk_a("ack_idle", 4'b0000, 2'd0);

        // Pointer now 3: all requesting wins 3 first, then rotates without bubbles
        ack_a = 1'b0;
        req_a = 4'b1111;
        tick();
        chk_a("ptr3", 4'b1000, 2'd3);
        ack_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_a("rot", 4'b0001 << rot_exp[k], rot_exp[k]);
        end
        req_a = 4'b0000;
        tick();
        chk_a("rot_end", 4'b0000, 2'd0);

        // Pointer 1: sole requester 2 is granted, then wins again after its own ack
        ack_a = 1'b0;
        req_a = 4'b0100;
        tick();
        chk_a("sole1", 4'b0100, 2'd2);
        ack_a = 1'b1;
        tick();
        chk_a("sole2", 4'b0100, 2'd2);
        ack_a = 1'b0;
        tick();
        chk_a("sole_hold", 4'b0100, 2'd2);

        // Reset mid-grant drops the grant and clears the pointer (was 3)
        rst_n = 1'b0;
        tick();
        chk_a("midrst", 4'b0000, 2'd0);
        rst_n = 1'b1;
        req_a = 4'b1111;
        tick();
        chk_a("postrst", 4'b0001, 2'd0);
        ack_a = 1'b1;
        req_a = 4'b0000;
        tick();
        chk_a("postrst_idle", 4'b0000, 2'd0);
        ack_a = 1'b0;
        req_a = 4'b0100;
        tick();
        chk_a("postrst_req2", 4'b0100, 2'd2);

        // N=5 wrap: grant 3, ack with no requests leaves ptr=4
        req_b = 5'b01000;
        tick();
        chk_b("b_g3", 5'b01000, 3'd3);
        ack_b = 1'b1;
        req_b = 5'b00000;
        tick();
        chk_b("b_idle", 5'b00000, 3'd0);
        ack_b = 1'b0;
        req_b = 5'b00011;
        tick();
        chk_b("b_wrap0", 5'b00001, 3'd0);
        ack_b = 1'b1;
        tick();
        chk_b("b_next1", 5'b00010, 3'd1);
        req_b = 5'b00000;
        tick();
        chk_b("b_end", 5'b00000, 3'd0);
        ack_b = 1'b0;

        // Fixed priority: index 1 always beats index 3
        req_c = 4'b1010;
        tick();
        chk_c("fix_first", 4'b0010, 2'd1);
        ack_c = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_c("fix", 4'b0010, 2'd1);
        end
        req_c = 4'b0000;
        tick();
        chk_c("fix_end", 4'b0000, 2'd0);
        ack_c = 1'b0;
        req_c = 4'b1000;
        tick();
        chk_c("fix_only3", 4'b1000, 2'd3);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
